// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width constants for the Booth multiplier
package mult_pkg;

    localparam int OP_W  = 32;
    localparam int ITER  = 32;
    localparam int ACC_W = 33;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - combinational 33-bit Booth add/subtract of accumulator and multiplicand
module booth_addsub
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] m,
    input  logic [1:0]       sel,
    output logic [ACC_W-1:0] sum
);

    // sel is the Booth pair {P[1], P[0]}: 01 adds M, 10 subtracts M, 00/11 pass through
    always_comb begin
        sum = acc;
        case (sel)
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - radix-2 Booth 32x32 signed multiplier; ovf output built with MULT_OVF_EN
module booth_mult
    import mult_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_W-1:0]     x,
    input  logic [OP_W-1:0]     y,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   prod
`ifdef MULT_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int P_W = ACC_W + OP_W + 1;

    state_t           state;
    logic [P_W-1:0]   p;
    logic [ACC_W-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_next;

    booth_addsub u_addsub (
        .acc (p[P_W-1:OP_W+1]),
        .m   (m),
        .sel (p[1:0]),
        .sum (acc_next)
    );

    // busy/done are registered from the state held during the previous cycle,
    // so done and the new prod appear together one cycle after the FSM enters DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            p     <= '0;
            m     <= '0;
            cnt   <= '0;
`ifdef MULT_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    done <= (state == DONE);
                    if (state == DONE) begin
                        prod <= p[2*OP_W:1];
`ifdef MULT_OVF_EN
                        ovf  <= !((&p[2*OP_W:OP_W]) || !(|p[2*OP_W:OP_W]));
`endif
                    end
                    if (start) begin
                        m     <= {x[OP_W-1], x};
                        p     <= {{ACC_W{1'b0}}, y, 1'b0};
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    p    <= {acc_next[ACC_W-1], acc_next, p[OP_W:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - self-checking bench for booth_mult (ovf checks built with MULT_OVF_EN)
module tb_booth_mult;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [63:0] prod;
`ifdef MULT_OVF_EN
    logic        ovf;
`endif

    int tests = 0;
    int fails = 0;

    booth_mult dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .prod  (prod)
`ifdef MULT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
    endfunction

    function automatic logic model_ovf(input logic [63:0] pr);
        longint s;
        s = pr;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch with start sampled at the next edge (edge 0), then wait for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        x = a;
        y = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp_p;
        exp_p = model_prod(a, b);
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        check({tag, "_prod"}, prod, exp_p);
`ifdef MULT_OVF_EN
        check({tag, "_ovf"}, {63'b0, ovf}, {63'b0, model_ovf(exp_p)});
`endif
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0;
        start = 1'b1;
        x = 32'd9;
        y = 32'd9;
        tick();
        tick();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_prod", prod, 64'd0);
`ifdef MULT_OVF_EN
        check("rst_ovf", {63'b0, ovf}, 64'd0);
`endif
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_after_rst_busy", {63'b0, busy}, 64'd0);

        run_op(32'd3, 32'd5, lat, bcnt);
        check("lat_3x5", 64'(lat), 64'd33);
        check("busy_cycles_3x5", 64'(bcnt), 64'd32);
        check("prod_3x5", prod, 64'h0000_0000_0000_000F);
        check_result("r_3x5", 32'd3, 32'd5);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("prod_hold", prod, 64'h0000_0000_0000_000F);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("prod_m1xm1", prod, 64'h0000_0000_0000_0001);
        run_op(32'hFFFF_FFFF, 32'd2, lat, bcnt);
        check("prod_m1x2", prod, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(32'h8000_0000, 32'h8000_0000, lat, bcnt);
        check("prod_minxmin", prod, 64'h4000_0000_0000_0000);
`ifdef MULT_OVF_EN
        check("ovf_minxmin", {63'b0, ovf}, 64'd1);
`endif
        tick();

        // start during RUN is ignored; start in the done cycle begins the next op
        x = 32'd3;
        y = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                x = 32'd7;
                y = 32'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("lat_ignore", 64'(lat), 64'd33);
        check("prod_ignore", prod, 64'd15);
        run_op(32'd7, 32'd7, lat, bcnt);
        check("lat_b2b", 64'(lat), 64'd33);
        check("prod_b2b", prod, 64'd49);

        // reset asserted at RUN cycle 10 aborts without a done pulse
        x = 32'd3;
        y = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_prod", prod, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        run_op(32'd2, 32'd2, lat, bcnt);
        check("prod_after_abort", prod, 64'd4);

`ifdef MULT_OVF_EN
        run_op(32'h0001_0000, 32'h0001_0000, lat, bcnt);
        check("prod_2p32", prod, 64'h0000_0001_0000_0000);
        check("ovf_2p32", {63'b0, ovf}, 64'd1);
        run_op(32'h0000_7FFF, 32'h0000_7FFF, lat, bcnt);
        check("ovf_7fff", {63'b0, ovf}, 64'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = $urandom_range(0, 200) - 100;
            if (i % 4 == 2) rb = $urandom_range(0, 65535);
            run_op(ra, rb, lat, bcnt);
            check("rand_lat", 64'(lat), 64'd33);
            check_result("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 Ports SHALL be as follows, clock and reset first:
  clock  in  1  single clock; all state changes on the rising edge.
  reset  in  1  reset; synchronous and active-low.
  start  in  1  request to load operands and begin a multiply.
  x      in  32  multiplicand, two's complement.
  y      in  32  multiplier, two's complement.
  busy   out  1  high while an operation is in progress.
  done   out  1  one-cycle pulse; prod valid.
  prod   out  64  signed product x*y.
  ovf    out  1  present only with MULT_OVF_EN; product does not fit in 32-bit signed.
REQ-002 Parameter: none; widths are fixed at 32x32->64.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-004 In IDLE or DONE, start=1 SHALL capture x into M (sign-extended to 33 bits) and load P = {33'b0, y, 1'b0}, clear counter, and go to RUN.
REQ-005 In IDLE or DONE, start=0 SHALL go to or stay in IDLE.
REQ-006 start SHALL be ignored in RUN, with no effect on the operation or its operands.
REQ-007 Each RUN cycle SHALL examine P[1:0]:
  01 -> P[65:33] += M
  10 -> P[65:33] -= M
  00/11 -> no change
  then P SHALL be arithmetic-shifted right by 1.
REQ-008 Add/subtract SHALL be 33 bits wide so that M = -2^31 never overflows the accumulator.
REQ-009 RUN SHALL last exactly 32 cycles; the counter runs 0..31, and after count 31 the FSM goes to DONE.
REQ-010 In DONE, done SHALL be 1 for one cycle and prod SHALL equal P[64:1].
REQ-011 Latency: start sampled at edge k -> done high in the cycle after edge k+33.
REQ-012 prod SHALL hold its value from DONE until the next DONE; it is not updated during RUN.
REQ-013 busy SHALL be 1 exactly in RUN.
REQ-014 start in the DONE cycle SHALL be accepted for back-to-back operation, with done still pulsing that cycle.

Reset
REQ-015 With reset=0 at a rising edge:
  state SHALL go to IDLE.
  busy, done, ovf SHALL go to 0.
  prod, P, M, counter SHALL go to 0.
REQ-016 Reset mid-RUN SHALL abort the operation with no done pulse; the next start SHALL operate normally.
REQ-017 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-018 Macro MULT_OVF_EN defined: the ovf port SHALL exist and SHALL be registered in DONE as 1 iff prod[63:31] is not all-equal bits; ovf holds with prod.
REQ-019 Macro MULT_OVF_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 A shared package mult_pkg SHALL hold:
  the state enum (IDLE, RUN, DONE).
  constants: operand width 32, iteration count 32, accumulator width 33.
REQ-021 One sub-module, booth_addsub, SHALL be instantiated:
  combinational 33-bit add/sub of accumulator and M.
  op select decoded from P[1:0].
  outputs the pre-shift accumulator.
REQ-022 The shift, counter and FSM SHALL live in booth_mult.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  x=3, y=5, start at edge 0 -> busy for 32 cycles, done after edge 33, prod=0x000000000000000F, ovf=0.
  x=0xFFFFFFFF, y=0xFFFFFFFF -> prod=0x0000000000000001; x=0xFFFFFFFF, y=2 -> prod=0xFFFFFFFFFFFFFFFE.
  x=y=0x80000000 -> prod=0x4000000000000000 (ovf=1 with MULT_OVF_EN).
  start pulsed with x=7, y=7 during RUN of 3*5 -> ignored, result 15; start in the DONE cycle with 7*7 -> done pulses, next prod=49.
  reset=0 at RUN cycle 10 -> busy=0, done never pulses, prod=0; next start 2*2 -> prod=4.
  MULT_OVF_EN, x=y=0x00010000 -> prod=0x0000000100000000, ovf=1; x=y=0x00007FFF -> ovf=0.
